uart_tx_fifo: RTL and testbench

- Byte queue and send sequencer sitting directly upstream of uart_byte_tx.
- Producers (command responders, echo logic) push bytes at clock rate. The block releases them one at a time on the Data/Send_Go/Tx_done handshake uart_byte_tx expects.
- Removes the single-byte-in-flight limitation of driving uart_byte_tx directly from Rx_done.

---
 rtl/uart_tx_fifo_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-side signal bundle for uart_tx_fifo.
// The master side pushes bytes and returns Tx_done; the slave side is the FIFO itself.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clr_ovf;
  logic [DATA_W-1:0] tx_data;
  logic              tx_go;
  logic              tx_done;
  logic              busy;

  modport master (
    output wr_en, wr_data, clr_ovf, tx_done,
    input  full, empty, count, overflow, tx_data, tx_go, busy
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf, tx_done,
    output full, empty, count, overflow, tx_data, tx_go, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of uart_byte_tx: buffers pushes at clock rate and releases
// one byte per Send_Go/Tx_done handshake, with a one-cycle gap between bytes.
module uart_tx_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int            DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] tx_data;
  logic              tx_go;
  logic              overflow;
  logic              full;
  logic              empty;
  logic              push;
  logic              drop;
  logic              pop;

  // full/empty come from the registered count, so a push while full is
  // dropped even when the sequencer pops on the same edge.
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = bus.wr_en & ~full;
  assign drop  = bus.wr_en & full;
  assign pop   = (state == IDLE) & ~empty;

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count;
  assign bus.overflow = overflow;
  assign bus.tx_data  = tx_data;
  assign bus.tx_go    = tx_go;
  assign bus.busy     = (state != IDLE) | ~empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A dropped push outranks a simultaneous clear.
      if (drop) begin
        overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      tx_data <= '0;
      tx_go   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + PTR_ONE;
            tx_go   <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (bus.tx_done) begin
            tx_go <= 1'b0;
            state <= GAP;
          end
        end
        // One dead cycle so the transmitter always sees Send_Go fall.
        GAP: begin
          tx_go <= 1'b0;
          state <= IDLE;
        end
        default: begin
          tx_go <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based model of the byte stream
// and the Send_Go/Tx_done timing rules.
module tb_uart_tx_fifo;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic reset;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  uart_tx_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bytes waiting, whether a byte is on the wire, and the earliest edge
  // at which the next byte may be released after a Tx_done.
  logic [7:0] q_model[$];
  logic [7:0] exp_order[$];
  logic [7:0] sent_log[$];
  logic       m_go;
  logic [7:0] m_data;
  logic       m_ovf;
  logic       m_gap;
  int         edge_no;
  int         ready_edge;

  logic prev_go;
  logic auto_done;
  int   resp_delay;
  int   resp_cnt;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    q_model.delete();
    m_go       = 1'b0;
    m_data     = 8'h00;
    m_ovf      = 1'b0;
    m_gap      = 1'b0;
    ready_edge = edge_no;
  endtask

  task automatic modelEdge(input logic we, input logic [7:0] wd, input logic done, input logic clr);
    logic full_pre;
    logic pop_ok;
    logic drop;
    full_pre = (q_model.size() == DEPTH);
    pop_ok   = !m_go && (edge_no >= ready_edge) && (q_model.size() != 0);
    drop     = we && full_pre;
    m_gap    = 1'b0;
    if (m_go && done) begin
      m_go       = 1'b0;
      m_gap      = 1'b1;
      ready_edge = edge_no + 2;
    end
    if (pop_ok) begin
      m_data = q_model.pop_front();
      m_go   = 1'b1;
    end
    if (we && !full_pre) begin
      q_model.push_back(wd);
      exp_order.push_back(wd);
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    edge_no++;
  endtask

  function automatic logic modelBusy();
    return m_go || m_gap || (q_model.size() != 0);
  endfunction

  task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic done, input logic clr);
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.tx_done = done;
    bus.clr_ovf = clr;
    modelEdge(we, wd, done, clr);
    @(posedge clk);
    #1;
    checkOutput("tx_go",    bus.tx_go,    m_go);
    checkOutput("tx_data",  bus.tx_data,  m_data);
    checkOutput("count",    bus.count,    q_model.size());
    checkOutput("full",     bus.full,     q_model.size() == DEPTH);
    checkOutput("empty",    bus.empty,    q_model.size() == 0);
    checkOutput("overflow", bus.overflow, m_ovf);
    checkOutput("busy",     bus.busy,     modelBusy());
    if (bus.tx_go && !prev_go) sent_log.push_back(bus.tx_data);
    prev_go = bus.tx_go;
  endtask

  // Stand-in for uart_byte_tx: pulse Tx_done after tx_go has been high resp_delay cycles.
  task automatic respond(output logic done);
    done = 1'b0;
    if (auto_done && prev_go) begin
      resp_cnt++;
      if (resp_cnt >= resp_delay) begin
        done     = 1'b1;
        resp_cnt = 0;
      end
    end
  endtask

  task automatic stepAuto(input logic we, input logic [7:0] wd, input logic clr);
    logic d;
    respond(d);
    applyStimulus(we, wd, d, clr);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (modelBusy() && n < budget) begin
      stepAuto(1'b0, 8'h00, 1'b0);
      n++;
    end
    checkOutput("drain_in_budget", n < budget, 1);
  endtask

  task automatic compareOrder(input string tag);
    checkOutput({tag, "_len"}, sent_log.size(), exp_order.size());
    for (int i = 0; i < sent_log.size() && i < exp_order.size(); i++) begin
      checkOutput({tag, "_byte"}, sent_log[i], exp_order[i]);
    end
    sent_log.delete();
    exp_order.delete();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic d;
    logic we;
    int   pushed;
    int   max_cnt;

    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.tx_done = 1'b0;
    bus.clr_ovf = 1'b0;
    auto_done   = 1'b0;
    resp_delay  = 4;
    resp_cnt    = 0;
    prev_go     = 1'b0;
    edge_no     = 0;
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tx_go",    bus.tx_go,    0);
    checkOutput("rst_tx_data",  bus.tx_data,  0);
    checkOutput("rst_count",    bus.count,    0);
    checkOutput("rst_empty",    bus.empty,    1);
    checkOutput("rst_full",     bus.full,     0);
    checkOutput("rst_overflow", bus.overflow, 0);
    checkOutput("rst_busy",     bus.busy,     0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single byte");
    auto_done  = 1'b1;
    resp_delay = 5;
    stepAuto(1'b1, 8'h55, 1'b0);
    checkOutput("single_count_after_push", bus.count, 1);
    checkOutput("single_go_not_yet", bus.tx_go, 0);
    stepAuto(1'b0, 8'h00, 1'b0);
    checkOutput("single_go", bus.tx_go, 1);
    checkOutput("single_data", bus.tx_data, 8'h55);
    drain(100);
    checkOutput("single_empty", bus.empty, 1);
    checkOutput("single_busy", bus.busy, 0);
    compareOrder("single");

    $display("[TB] burst");
    resp_delay = 20;
    for (int i = 1; i <= 5; i++) stepAuto(1'b1, 8'(i), 1'b0);
    drain(500);
    compareOrder("burst");

    $display("[TB] fill and overflow");
    auto_done = 1'b0;
    for (int i = 0; i < 18; i++) stepAuto(1'b1, 8'h10 + 8'(i), 1'b0);
    checkOutput("fill_count", bus.count, 16);
    checkOutput("fill_full", bus.full, 1);
    checkOutput("fill_overflow", bus.overflow, 1);
    stepAuto(1'b0, 8'h00, 1'b1);
    checkOutput("fill_clr_ovf", bus.overflow, 0);

    $display("[TB] push while full on the pop edge");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    checkOutput("simul_count", bus.count, 15);
    checkOutput("simul_overflow", bus.overflow, 1);
    checkOutput("simul_data", bus.tx_data, 8'h11);
    auto_done  = 1'b1;
    resp_delay = 3;
    drain(1000);
    compareOrder("fill");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("idle_done_go", bus.tx_go, 0);
    checkOutput("idle_done_data", bus.tx_data, 8'h20);
    checkOutput("idle_done_busy", bus.busy, 0);
    stepAuto(1'b0, 8'h00, 1'b1);

    $display("[TB] wrap-around stream");
    pushed  = 1;
    max_cnt = 0;
    applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int n = 0; n < 3000 && (pushed < 40 || modelBusy()); n++) begin
      respond(d);
      we = d && (pushed < 40);
      applyStimulus(we, 8'($urandom), d, 1'b0);
      if (we) pushed++;
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      if (d) resp_delay = $urandom_range(1, 6);
    end
    checkOutput("wrap_pushed", pushed, 40);
    checkOutput("wrap_max_count_le2", max_cnt <= 2, 1);
    checkOutput("wrap_overflow", bus.overflow, 0);
    compareOrder("wrap");

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      respond(d);
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), d, $urandom_range(0, 15) == 0);
      if (d) resp_delay = $urandom_range(1, 8);
    end
    drain(3000);
    compareOrder("random");

    $display("[TB] reset during SEND");
    auto_done = 1'b0;
    stepAuto(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) stepAuto(1'b1, 8'($urandom), 1'b0);
    checkOutput("pre_reset_count", bus.count, 6);
    checkOutput("pre_reset_go", bus.tx_go, 1);
    #2;
    bus.wr_en   = 1'b0;
    bus.tx_done = 1'b0;
    bus.clr_ovf = 1'b0;
    reset       = 1'b1;
    #1;
    checkOutput("mid_reset_go", bus.tx_go, 0);
    checkOutput("mid_reset_count", bus.count, 0);
    checkOutput("mid_reset_empty", bus.empty, 1);
    checkOutput("mid_reset_overflow", bus.overflow, 0);
    checkOutput("mid_reset_busy", bus.busy, 0);
    modelReset();
    prev_go  = 1'b0;
    resp_cnt = 0;
    sent_log.delete();
    exp_order.delete();
    @(negedge clk);
    reset = 1'b0;
    auto_done  = 1'b1;
    resp_delay = 6;
    stepAuto(1'b1, 8'hA5, 1'b0);
    drain(200);
    checkOutput("post_reset_data", bus.tx_data, 8'hA5);
    compareOrder("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
